sram_responder: RTL and testbench

- Data-memory responder that sits on the processor's SRAM port and serves read/write requests from the core's FSM.
- Owns the storage array and scrubs it to zero after every reset.
- Provides a valid/ready preload port so the bench or a loader can fill data while the core is idle.
- Reports protocol violations on a single-cycle error strobe.

---
 rtl/sram_responder.sv | 109 ++++++++++
 tb/tb_sram_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Data-memory responder for the core's SRAM port: scrubs the array to zero after reset,
// serves single-cycle reads/writes, accepts idle-cycle preloads and flags protocol violations.
module sram_responder #(
    parameter int unsigned N              = 8,
    parameter int unsigned RF_addressBits = 3,
    parameter int unsigned ADDR_W         = 2 ** RF_addressBits
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SRAM_readEnable,
    input  logic              SRAM_writeEnable,
    input  logic [ADDR_W-1:0] SRAM_address,
    input  logic [N-1:0]      SRAM_data_in,
    output logic [N-1:0]      SRAM_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_address,
    input  logic [N-1:0]      load_data,
    output logic              init_done,
    output logic              access_error
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clear_ptr;
    logic [N-1:0]      r_sram_data;
    logic              r_init_done;
    logic              r_access_error;
    logic [N-1:0]      r_mem [DEPTH];

    logic              w_ready;
    logic              w_rd;
    logic              w_wr;
    logic              w_load;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [N-1:0]      w_mem_wdata;

    assign w_ready    = (r_state == READY);
    assign w_rd       = w_ready && SRAM_readEnable && !SRAM_writeEnable;
    assign w_wr       = w_ready && SRAM_writeEnable && !SRAM_readEnable;
    assign load_ready = w_ready && !SRAM_readEnable && !SRAM_writeEnable;
    assign w_load     = load_valid && load_ready;

    // Single array write port: scrub while clearing, otherwise processor write before preload.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_clear_ptr;
        w_mem_wdata = '0;
        if (!w_ready) begin
            w_mem_we = 1'b1;
        end else if (w_wr) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = SRAM_address;
            w_mem_wdata = SRAM_data_in;
        end else if (w_load) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = load_address;
            w_mem_wdata = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= CLEAR;
            r_clear_ptr    <= '0;
            r_sram_data    <= '0;
            r_init_done    <= 1'b0;
            r_access_error <= 1'b0;
        end else begin
            r_access_error <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clear_ptr    <= r_clear_ptr + ADDR_W'(1);
                    r_access_error <= SRAM_readEnable || SRAM_writeEnable;
                    if (r_clear_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_access_error <= SRAM_readEnable && SRAM_writeEnable;
                    if (w_rd) begin
                        r_sram_data <= r_mem[SRAM_address];
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign SRAM_data    = r_sram_data;
    assign init_done    = r_init_done;
    assign access_error = r_access_error;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder: a driver applies directed and random traffic and
// queues expected outputs from an array model; a monitor pops and compares every cycle.
module tb_sram_responder;
    localparam int K_DATA = 0;
    localparam int K_ERR  = 1;
    localparam int K_INIT = 2;
    localparam int K_LRDY = 3;

    logic       clk;
    logic       rst_n;
    logic       re, we, lv;
    logic [7:0] addr, din, la, ld;
    logic [7:0] sram_data;
    logic       load_ready, init_done, access_error;

    sram_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .SRAM_readEnable (re),
        .SRAM_writeEnable(we),
        .SRAM_address    (addr),
        .SRAM_data_in    (din),
        .SRAM_data       (sram_data),
        .load_valid      (lv),
        .load_ready      (load_ready),
        .load_address    (la),
        .load_data       (ld),
        .init_done       (init_done),
        .access_error    (access_error)
    );

    typedef struct {
        int         when;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    // Reference model: plain array plus "edges left until the scrub is done".
    logic [7:0] ref_mem [256];
    logic [7:0] m_data;
    int         m_scrub_left;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_DATA:  return "SRAM_data";
            K_ERR:   return "access_error";
            K_INIT:  return "init_done";
            default: return "load_ready";
        endcase
    endfunction

    task automatic push(input int when, input int kind, input logic [7:0] val);
        exp_t e;
        e.when = when;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    // Monitor: outputs are stable 2 time units after the falling edge.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0 && q[0].when <= cyc) begin
                e = q.pop_front();
                case (e.kind)
                    K_DATA:  act = sram_data;
                    K_ERR:   act = {7'd0, access_error};
                    K_INIT:  act = {7'd0, init_done};
                    default: act = {7'd0, load_ready};
                endcase
                n_vec++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s at cycle %0d: actual=%0h required=%0h",
                             kname(e.kind), cyc, act, e.val);
                end
            end
        end
    end

    // Drive one cycle of inputs (already at a falling edge) and predict its effects.
    task automatic drive(input logic i_re, input logic i_we, input logic [7:0] i_a,
                         input logic [7:0] i_d, input logic i_lv, input logic [7:0] i_la,
                         input logic [7:0] i_ld);
        int   c;
        logic ready;
        logic err;
        re = i_re; we = i_we; addr = i_a; din = i_d;
        lv = i_lv; la = i_la; ld = i_ld;
        c     = cyc;
        ready = (m_scrub_left == 0);
        err   = 1'b0;
        push(c, K_LRDY, {7'd0, ready && !i_re && !i_we});
        if (!ready) begin
            err = i_re || i_we;
            m_scrub_left--;
        end else if (i_re && i_we) begin
            err = 1'b1;
        end else if (i_we) begin
            ref_mem[i_a] = i_d;
        end else if (i_re) begin
            m_data = ref_mem[i_a];
        end else if (i_lv) begin
            ref_mem[i_la] = i_ld;
        end
        push(c + 1, K_DATA, m_data);
        push(c + 1, K_ERR, {7'd0, err});
        push(c + 1, K_INIT, {7'd0, m_scrub_left == 0});
    endtask

    task automatic step(input logic i_re, input logic i_we, input logic [7:0] i_a,
                        input logic [7:0] i_d, input logic i_lv, input logic [7:0] i_la,
                        input logic [7:0] i_ld);
        @(negedge clk);
        drive(i_re, i_we, i_a, i_d, i_lv, i_la, i_ld);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic push_reset_state();
        push(cyc, K_DATA, 8'h00);
        push(cyc, K_ERR, 8'h00);
        push(cyc, K_INIT, 8'h00);
        push(cyc, K_LRDY, 8'h00);
    endtask

    // Reset asserted at a falling edge (between rising edges), held across one rising edge.
    task automatic do_reset();
        @(negedge clk);
        q.delete();
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; lv = 1'b0;
        m_data = 8'h00;
        m_scrub_left = 256;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        push_reset_state();
        @(negedge clk);
        push_reset_state();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_scrub();
        while (m_scrub_left > 0) idle();
    endtask

    initial begin
        int r;
        logic [7:0] a;
        rst_n = 1'b0;
        re = 1'b0; we = 1'b0; lv = 1'b0;
        addr = 8'h00; din = 8'h00; la = 8'h00; ld = 8'h00;
        m_data = 8'h00;
        m_scrub_left = 256;

        do_reset();
        // Requests during the scrub: ignored, each flagged; back-to-back violations.
        idle();
        wr(8'h33, 8'h99);
        rd(8'h10);
        step(1'b1, 1'b1, 8'h20, 8'h55, 1'b0, 8'h00, 8'h00);
        idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h34, 8'h66);
        wait_scrub();

        rd(8'h00); rd(8'h7F); rd(8'hFF); rd(8'h33); rd(8'h34);

        wr(8'h12, 8'hA5);
        rd(8'h12);
        idle(); idle(); idle();

        // Preload held while the processor reads; lands on the first idle cycle.
        step(1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 8'h40, 8'h3C);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 8'h3C);
        idle();
        rd(8'h40);

        step(1'b1, 1'b1, 8'h12, 8'hFF, 1'b0, 8'h00, 8'h00);
        idle();
        rd(8'h12);

        wr(8'hFF, 8'h01);
        wr(8'h00, 8'h02);
        rd(8'hFF);
        rd(8'h00);

        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 8'($urandom));
        for (int i = 0; i < 64; i++) rd(8'($urandom));

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            a = 8'($urandom_range(0, 15));
            step(r <= 3 || r == 7, (r >= 4 && r <= 6) || r == 7, a, 8'($urandom),
                 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end

        wr(8'h05, 8'h77);
        rd(8'h05);
        do_reset();
        wait_scrub();
        rd(8'h05);
        rd(8'h12);
        idle();
        idle();

        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            n_err += q.size();
            $display("FAIL scoreboard: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
